// File: rtl/imem_loader.sv
// imem_loader: assembles big-endian 16-bit words from a byte stream and writes them into instruction RAM.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, WRITE, CHECK, DONE} state_t;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    state_t            state_q, state_d;
    logic [15:0]       data_q, data_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              take;
    assign byte_ready = state_q inside {LOAD_HI, LOAD_LO, CHECK};
    assign take       = byte_valid && byte_ready && !abort;
    assign wr_en      = state_q == WRITE;
    assign wr_addr    = count_q[ADDR_W-1:0];
    assign wr_data    = data_q;
    assign cpu_hold   = state_q != DONE;
    assign load_done  = state_q == DONE;
    assign word_count = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        err_d   = err_q;
`endif
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_d = LOAD_HI;
                    count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
                    err_d   = 1'b0;
`endif
                end
                LOAD_HI: if (take) begin
                    data_d[15:8] = byte_in;
                    state_d      = LOAD_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d       = csum_q ^ byte_in;
`endif
                end
                LOAD_LO: if (take) begin
                    data_d[7:0] = byte_in;
                    state_d     = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ byte_in;
`endif
                end
                WRITE: begin
                    count_d = (count_q == FULL) ? count_q : count_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = (count_q < LAST) ? LOAD_HI : CHECK;
`else
                    state_d = (count_q < LAST) ? LOAD_HI : DONE;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: if (take) begin
                    state_d = (byte_in == csum_q) ? DONE : IDLE;
                    err_d   = byte_in != csum_q;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= err_d;
        end
    end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven image loads with a write scoreboard for imem_loader.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n, start, abort, byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready, wr_en, cpu_hold, load_done, err;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  word_count;

    typedef struct {logic [7:0] hi; logic [7:0] lo; logic [15:0] word;} vec_t;
    typedef struct {int addr; logic [15:0] data;} wr_t;
    vec_t vecs[16];
    wr_t  sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] xr;

    imem_loader #(.ADDR_W(4), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .load_done(load_done), .word_count(word_count), .err(err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wr_en: got addr %0d data %h expected no write at %0t", wr_addr, wr_data, $time);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(wr_addr), e.addr);
                chk("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!byte_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic load(input int first, input int last, input int gap);
        for (int i = first; i < last; i++) begin
            send_byte(vecs[i].hi, gap);
            sb.push_back('{addr: i, data: vecs[i].word});
            send_byte(vecs[i].lo, gap);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_word_count", 32'(word_count), 0);
        chk("start_err", 32'(err), 0);
        chk("start_byte_ready", 32'(byte_ready), 1);
        chk("start_load_done", 32'(load_done), 0);
    endtask

    // Called right after the last low byte is accepted: the DUT is in its WRITE cycle.
    task automatic finish_load();
        chk("last_wr_en", 32'(wr_en), 1);
        @(posedge clk); #1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("check_ready", 32'(byte_ready), 1);
        send_byte(xr, 0);
        chk("done_err", 32'(err), 0);
`endif
        chk("done_load_done", 32'(load_done), 1);
        chk("done_cpu_hold", 32'(cpu_hold), 0);
        chk("done_word_count", 32'(word_count), 16);
        chk("done_wr_en", 32'(wr_en), 0);
    endtask

    initial begin
        vecs[0]  = '{8'h01, 8'h23, 16'h0123}; vecs[1]  = '{8'h45, 8'h67, 16'h4567};
        vecs[2]  = '{8'h89, 8'hAB, 16'h89AB}; vecs[3]  = '{8'hCD, 8'hEF, 16'hCDEF};
        vecs[4]  = '{8'h13, 8'h57, 16'h1357}; vecs[5]  = '{8'h9B, 8'hDF, 16'h9BDF};
        vecs[6]  = '{8'h24, 8'h68, 16'h2468}; vecs[7]  = '{8'hAC, 8'hE0, 16'hACE0};
        vecs[8]  = '{8'hFE, 8'hDC, 16'hFEDC}; vecs[9]  = '{8'hBA, 8'h98, 16'hBA98};
        vecs[10] = '{8'h76, 8'h54, 16'h7654}; vecs[11] = '{8'h32, 8'h10, 16'h3210};
        vecs[12] = '{8'h0F, 8'h1E, 16'h0F1E}; vecs[13] = '{8'h2D, 8'h3C, 16'h2D3C};
        vecs[14] = '{8'h4B, 8'h5A, 16'h4B5A}; vecs[15] = '{8'h50, 8'h00, 16'h5000};
        xr = 8'h00;
        for (int i = 0; i < 16; i++) xr = xr ^ vecs[i].hi ^ vecs[i].lo;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        #12;
        chk("rst_byte_ready", 32'(byte_ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_word_count", 32'(word_count), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cpu_hold", 32'(cpu_hold), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle_ready", 32'(byte_ready), 0);
        chk("start_abort_idle_hold", 32'(cpu_hold), 1);

        do_start();
        load(0, 16, 0);
        finish_load();

        do_start();
        load(0, 3, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_load_hi_count", 32'(word_count), 3);
        chk("start_in_load_hi_ready", 32'(byte_ready), 1);
        load(3, 15, 1);
        load(15, 16, 0);
        finish_load();

        do_start();
        load(0, 5, 0);
        @(posedge clk); #1;
        chk("pre_abort_count", 32'(word_count), 5);
        abort = 1'b1; byte_in = 8'hAA; byte_valid = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_ready", 32'(byte_ready), 0);
        chk("abort_hold", 32'(cpu_hold), 1);
        chk("abort_done", 32'(load_done), 0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("abort_idle_ready", 32'(byte_ready), 0);
        byte_valid = 1'b0;
        do_start();
        load(0, 16, 0);
        finish_load();

        do_start();
        load(0, 2, 0);
        send_byte(vecs[2].hi, 0);
        chk("mid_lo_count", 32'(word_count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_byte_ready", 32'(byte_ready), 0);
        chk("async_rst_wr_data", 32'(wr_data), 0);
        chk("async_rst_word_count", 32'(word_count), 0);
        chk("async_rst_cpu_hold", 32'(cpu_hold), 1);
        chk("async_rst_load_done", 32'(load_done), 0);
        chk("async_rst_wr_en", 32'(wr_en), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        byte_valid = 1'b1; byte_in = 8'h55;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("post_rst_ready", 32'(byte_ready), 0);
        byte_valid = 1'b0;

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_start();
        load(0, 16, 0);
        @(posedge clk); #1;
        send_byte(xr ^ 8'h01, 0);
        chk("bad_csum_err", 32'(err), 1);
        chk("bad_csum_done", 32'(load_done), 0);
        chk("bad_csum_hold", 32'(cpu_hold), 1);
        chk("bad_csum_idle", 32'(byte_ready), 0);
`endif

        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, instruction-word address width.
REQ-002 SHALL have parameter DEPTH, default 16, words per image; DEPTH = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin image load.
REQ-006 SHALL have port abort  input  1  cancel load, return to IDLE.
REQ-007 SHALL have port byte_in  input  8  serial image byte.
REQ-008 SHALL have port byte_valid  input  1  byte_in valid.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port wr_en  output  1  instruction-RAM write strobe.
REQ-011 SHALL have port wr_addr  output  ADDR_W  instruction-RAM word address.
REQ-012 SHALL have port wr_data  output  16  instruction word.
REQ-013 SHALL have port cpu_hold  output  1  hold CPU in reset while the image is not valid.
REQ-014 SHALL have port load_done  output  1  complete image written.
REQ-015 SHALL have port word_count  output  ADDR_W+1  words written in the current load.
REQ-016 SHALL have port err  output  1  load failure flag (checksum only).

Function
REQ-017 SHALL have FSM states IDLE, LOAD_HI, LOAD_LO, WRITE, CHECK, DONE.
REQ-018 SHALL move IDLE->LOAD_HI and DONE->LOAD_HI on start=1.
REQ-019 SHALL ignore start in LOAD_HI, LOAD_LO, WRITE and CHECK.
REQ-020 SHALL accept a byte only on a cycle with byte_valid=1 and byte_ready=1.
REQ-021 SHALL drive byte_ready=1 only in LOAD_HI, LOAD_LO and CHECK.
REQ-022 SHALL treat words as big-endian: byte accepted in LOAD_HI -> wr_data[15:8], then LOAD_LO; byte accepted in LOAD_LO -> wr_data[7:0], then WRITE.
REQ-023 SHALL spend exactly one cycle in WRITE, with wr_en=1, wr_addr=word_count[ADDR_W-1:0] and wr_data = assembled word.
REQ-024 SHALL hold wr_en=0 in every state except WRITE.
REQ-025 SHALL increment word_count on the cycle after WRITE; word_count saturates at DEPTH with no wrap.
REQ-026 SHALL go WRITE->LOAD_HI when fewer than DEPTH words have been written, otherwise to CHECK (macro defined) or DONE (macro undefined).
REQ-027 SHALL drive cpu_hold=1 in all states except DONE, and cpu_hold=0 in DONE.
REQ-028 SHALL drive load_done=1 only in DONE.
REQ-029 SHALL clear word_count to 0 and err to 0 on entry to LOAD_HI from IDLE or DONE.
REQ-030 SHALL return any state to IDLE on the next edge when abort=1; abort overrides start and byte acceptance; no wr_en on that cycle.
REQ-031 SHALL latency: last byte accepted at edge N -> wr_en high cycle N+1 -> load_done high from cycle N+2 (macro undefined).
REQ-032 SHALL hold the current state and register values when byte_valid=0 (stall), with no timeout.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, word_count=0, load_done=0, err=0 and cpu_hold=1.
REQ-034 SHALL discard a partial load when reset is asserted mid-load; no further wr_en until a new start.

Configuration
REQ-035 SHALL use macro IMEM_LOADER_CHECKSUM_EN.
REQ-036 SHALL, with the macro defined, keep a running XOR of all 2*DEPTH data bytes; CHECK accepts one extra byte; if it matches the XOR, go to DONE; otherwise set err=1 and go to IDLE (cpu_hold stays 1).
REQ-037 SHALL, with the macro undefined, never enter CHECK; err is tied 0; no checksum logic.

Verification
REQ-038 SHALL cover: reset, start, then 32 bytes 0x01,0x23,...,0x50,0x00 (image 0x0123..0x5000) with valid held high -> 16 wr_en pulses at addr 0..15 with matching words; load_done=1, cpu_hold=0, word_count=16.
REQ-039 SHALL cover: byte_valid toggled 1/0 each cycle during the load -> identical writes; no byte lost or duplicated.
REQ-040 SHALL cover: abort asserted after 5 words -> IDLE, cpu_hold=1, no 6th wr_en; a new start -> word_count=0, first write at addr 0.
REQ-041 SHALL cover: rst_n pulsed low mid-LOAD_LO -> all outputs at reset values immediately, asynchronously.
REQ-042 SHALL cover, macro defined: correct XOR byte -> DONE with err=0; XOR^0x01 -> err=1, state IDLE, load_done=0.
REQ-043 SHALL cover: start and abort asserted together in IDLE -> remains IDLE; start pulsed during LOAD_HI -> no effect.
